// File: rtl/calc_input_cond_pkg.sv
// Shared constants for the calculator input conditioner: default debounce length,
// switch bus width, and the counter-width helper.
package calc_input_cond_pkg;

    // Simulation-friendly default; the board build overrides this to 1_000_000.
    localparam int CALC_DEBOUNCE_CYCLES = 16;
    localparam int CALC_SW_W            = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer plus debounce counter for one button; level changes
// DEBOUNCE_CYCLES+1 edges after s1 samples a held change, rise_pulse is a registered one-cycle strobe.
module debounce_cell
    import calc_input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic btnu,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int              CNT_W   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Commit the new level; strobe only on a debounced 0->1.
            stable_d = s2_q;
            cnt_d    = '0;
            pulse_d  = s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btnu) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            s1_q     <= din;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/calc_input_cond.sv
// Board-pin conditioner for calc: debounced btnl/btnc/btnr levels, one-cycle btnd strobe,
// and a two-flop synchronized sw bus (2-edge latency, no debounce).
module calc_input_cond
    import calc_input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES,
    parameter int SW_W            = CALC_SW_W
) (
    input  logic            clk,
    input  logic            btnu,
    input  logic            btnl_raw,
    input  logic            btnc_raw,
    input  logic            btnr_raw,
    input  logic            btnd_raw,
    input  logic [SW_W-1:0] sw_raw,
    output logic            btnl,
    output logic            btnc,
    output logic            btnr,
    output logic            btnd,
    output logic [SW_W-1:0] sw
);

    logic [SW_W-1:0] sw_s1_q;
    logic [SW_W-1:0] sw_s2_q;
    logic            unused_rise_l;
    logic            unused_rise_c;
    logic            unused_rise_r;
    logic            unused_level_d;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnl (
        .clk        (clk),
        .btnu       (btnu),
        .din        (btnl_raw),
        .level      (btnl),
        .rise_pulse (unused_rise_l)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnc (
        .clk        (clk),
        .btnu       (btnu),
        .din        (btnc_raw),
        .level      (btnc),
        .rise_pulse (unused_rise_c)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnr (
        .clk        (clk),
        .btnu       (btnu),
        .din        (btnr_raw),
        .level      (btnr),
        .rise_pulse (unused_rise_r)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnd (
        .clk        (clk),
        .btnu       (btnu),
        .din        (btnd_raw),
        .level      (unused_level_d),
        .rise_pulse (btnd)
    );

    // sw only needs metastability protection; calc samples it on the btnd strobe.
    always_ff @(posedge clk) begin
        if (btnu) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_raw;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign sw = sw_s2_q;

endmodule

// File: tb/tb_calc_input_cond.sv
// Directed bench for calc_input_cond with DEBOUNCE_CYCLES=4.
module tb_calc_input_cond;

    logic        clk = 1'b0;
    logic        btnu;
    logic        btnl_raw, btnc_raw, btnr_raw, btnd_raw;
    logic [15:0] sw_raw;
    logic        btnl, btnc, btnr, btnd;
    logic [15:0] sw;

    int          checks   = 0;
    int          failures = 0;

    int          np;
    int          first_idx;
    int          tot;
    logic [15:0] sw_at;
    logic [2:0]  lv_at;
    logic        l_seen;
    logic        l_seen_a;

    always #5 clk = ~clk;

    calc_input_cond #(.DEBOUNCE_CYCLES(4), .SW_W(16)) dut (
        .clk      (clk),
        .btnu     (btnu),
        .btnl_raw (btnl_raw),
        .btnc_raw (btnc_raw),
        .btnr_raw (btnr_raw),
        .btnd_raw (btnd_raw),
        .sw_raw   (sw_raw),
        .btnl     (btnl),
        .btnc     (btnc),
        .btnr     (btnr),
        .btnd     (btnd),
        .sw       (sw)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n edges; inputs may be changed right after return.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n edges, counting btnd pulses; edge index 1 is the first edge after the call.
    task automatic watch(input int n);
        np        = 0;
        first_idx = -1;
        sw_at     = '0;
        lv_at     = '0;
        l_seen    = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (btnd === 1'b1) begin
                np++;
                if (first_idx < 0) begin
                    first_idx = i;
                    sw_at     = sw;
                    lv_at     = {btnl, btnc, btnr};
                end
            end
            if (btnl === 1'b1) l_seen = 1'b1;
        end
    endtask

    initial begin
        // Reset with every input asserted.
        btnu = 1'b1;
        btnl_raw = 1'b1; btnc_raw = 1'b1; btnr_raw = 1'b1; btnd_raw = 1'b1;
        sw_raw = 16'hFFFF;
        step(1);
        chk("rst_lvls", {29'd0, btnl, btnc, btnr}, 32'd0);
        chk("rst_btnd", {31'd0, btnd}, 32'd0);
        chk("rst_sw", {16'd0, sw}, 32'd0);
        step(1);
        chk("rst2_sw", {16'd0, sw}, 32'd0);
        btnu = 1'b0;
        step(1);
        chk("rel_sw_e1", {16'd0, sw}, 32'd0);
        step(1);
        chk("rel_sw_e2", {16'd0, sw}, 32'h0000FFFF);
        watch(3);
        chk("rel_nopulse_early", np, 0);
        chk("rel_lvls_early", {29'd0, btnl, btnc, btnr}, 32'd0);
        step(1);
        chk("rel_lvls_e5", {29'd0, btnl, btnc, btnr}, 32'd7);
        chk("rel_pulse_e5", {31'd0, btnd}, 32'd1);
        step(1);
        chk("rel_pulse_end", {31'd0, btnd}, 32'd0);
        watch(10);
        chk("rel_held_nopulse", np, 0);

        // Clean press.
        btnl_raw = 1'b0; btnc_raw = 1'b0; btnr_raw = 1'b0; btnd_raw = 1'b0;
        watch(10);
        chk("release_nopulse", np, 0);
        chk("release_lvls", {29'd0, btnl, btnc, btnr}, 32'd0);
        btnd_raw = 1'b1;
        watch(30);
        chk("clean_count", np, 1);
        chk("clean_at", first_idx, 6);
        btnd_raw = 1'b0;
        watch(15);
        chk("clean_release_nopulse", np, 0);

        // Bounce 1,0,1,0 at 2-cycle intervals, then hold.
        tot = 0;
        btnd_raw = 1'b1; watch(2); tot += np;
        btnd_raw = 1'b0; watch(2); tot += np;
        btnd_raw = 1'b1; watch(2); tot += np;
        btnd_raw = 1'b0; watch(2); tot += np;
        chk("bounce_nopulse", tot, 0);
        btnd_raw = 1'b1;
        watch(20);
        chk("bounce_count", np, 1);
        chk("bounce_at", first_idx, 6);
        btnd_raw = 1'b0;
        watch(10);

        // Three-cycle glitch on btnl.
        btnl_raw = 1'b1;
        watch(3);
        l_seen_a = l_seen;
        btnl_raw = 1'b0;
        watch(15);
        chk("glitch_btnl", {31'd0, l_seen_a | l_seen}, 32'd0);

        // Level select plus strobe.
        sw_raw = 16'h1234;
        btnl_raw = 1'b1; btnc_raw = 1'b0; btnr_raw = 1'b1;
        watch(10);
        btnd_raw = 1'b1;
        watch(20);
        chk("sel_count", np, 1);
        chk("sel_at", first_idx, 6);
        chk("sel_sw", {16'd0, sw_at}, 32'h00001234);
        chk("sel_lvls", {29'd0, lv_at}, 32'd5);
        btnd_raw = 1'b0; btnl_raw = 1'b0; btnr_raw = 1'b0;
        watch(10);

        // Reset while the btnd counter is at 2.
        btnd_raw = 1'b1;
        watch(4);
        chk("midrst_pre_nopulse", np, 0);
        btnu = 1'b1;
        step(1);
        chk("midrst_btnd", {31'd0, btnd}, 32'd0);
        chk("midrst_sw", {16'd0, sw}, 32'd0);
        btnu = 1'b0;
        watch(20);
        chk("midrst_count", np, 1);
        chk("midrst_at", first_idx, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
